pic_fetch_unit: RTL and testbench

//  Instruction-fetch stage that sits directly upstream of the 14-bit program ROM.

---
 rtl/mcu_pkg.sv | 21 ++
 rtl/call_stack.sv | 58 +++++
 rtl/pic_fetch_unit.sv | 92 +++++++++
 tb/tb_pic_fetch_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared MCU constants and types used by the fetch unit, program ROM and decoder.
package mcu_pkg;

  localparam int ADDR_W      = 11;
  localparam int INSTR_W     = 14;
  localparam int STACK_DEPTH = 8;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam instr_t NOP_INSTR = 14'h0000;

  // Next-PC source, listed from lowest to highest priority
  typedef enum logic [1:0] {
    FETCH_SEQ,
    FETCH_JUMP,
    FETCH_CALL,
    FETCH_RET
  } fetch_sel_e;

endpackage

// File: rtl/call_stack.sv
// Circular hardware call stack with saturating occupancy and sticky overflow/underflow flags.
module call_stack
  import mcu_pkg::*;
#(
  parameter  int DEPTH = mcu_pkg::STACK_DEPTH,
  parameter  int W     = mcu_pkg::ADDR_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     data_in,
  output logic [W-1:0]     data_out,
  output logic [LVL_W-1:0] lvl,
  output logic             ovf,
  output logic             unf
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wp;

  // Top of stack sits just below the write pointer; on underflow this wraps to the oldest slot
  assign data_out = mem[wp - PTR_ONE];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      lvl <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (pop) begin
      wp <= wp - PTR_ONE;
      if (lvl == '0) begin
        unf <= 1'b1;
      end else begin
        lvl <= lvl - LVL_ONE;
      end
    end else if (push) begin
      mem[wp] <= data_in;
      wp      <= wp + PTR_ONE;
      if (lvl == LVL_MAX) begin
        ovf <= 1'b1;
      end else begin
        lvl <= lvl + LVL_ONE;
      end
    end
  end

endmodule

// File: rtl/pic_fetch_unit.sv
// Instruction-fetch stage: PC drives the ROM address, ROM word is latched into IR,
// with goto/call/return redirects and an 8-level call stack.
module pic_fetch_unit
  import mcu_pkg::*;
#(
  parameter int                 ADDR_W      = mcu_pkg::ADDR_W,
  parameter int                 INSTR_W     = mcu_pkg::INSTR_W,
  parameter int                 STACK_DEPTH = mcu_pkg::STACK_DEPTH,
  parameter logic [INSTR_W-1:0] NOP_INSTR   = mcu_pkg::NOP_INSTR
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         jump_en,
  input  logic                         call_en,
  input  logic                         ret_en,
  input  logic [ADDR_W-1:0]            jump_addr,
  input  logic                         flush,
  input  logic [INSTR_W-1:0]           rom_data,
  output logic [ADDR_W-1:0]            rom_addr,
  output logic [INSTR_W-1:0]           ir,
  output logic [ADDR_W-1:0]            ir_pc,
  output logic [$clog2(STACK_DEPTH):0] stack_lvl,
  output logic                         stack_ovf,
  output logic                         stack_unf
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] ret_addr;
  logic              push;
  logic              pop;
  fetch_sel_e        sel;

  always_comb begin
    sel = FETCH_SEQ;
    if (ret_en) begin
      sel = FETCH_RET;
    end else if (call_en) begin
      sel = FETCH_CALL;
    end else if (jump_en) begin
      sel = FETCH_JUMP;
    end
  end

  // Stall freezes the stack too, so push/pop are gated here rather than inside the stack
  assign push     = !stall && (sel == FETCH_CALL);
  assign pop      = !stall && (sel == FETCH_RET);
  assign rom_addr = pc;

  call_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_call_stack (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .data_in  (ir_pc + ADDR_ONE),
    .data_out (ret_addr),
    .lvl      (stack_lvl),
    .ovf      (stack_ovf),
    .unf      (stack_unf)
  );

  // Any redirect replaces the word already fetched behind it with a NOP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= '0;
      ir    <= NOP_INSTR;
      ir_pc <= '0;
    end else if (!stall) begin
      ir_pc <= pc;
      unique case (sel)
        FETCH_RET: begin
          pc <= ret_addr;
          ir <= NOP_INSTR;
        end
        FETCH_CALL, FETCH_JUMP: begin
          pc <= jump_addr;
          ir <= NOP_INSTR;
        end
        default: begin
          pc <= pc + ADDR_ONE;
          ir <= flush ? NOP_INSTR : rom_data;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pic_fetch_unit.sv
// Directed self-checking bench for pic_fetch_unit with a small combinational ROM model.
module tb_pic_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        jump_en;
  logic        call_en;
  logic        ret_en;
  logic [10:0] jump_addr;
  logic        flush;
  logic [13:0] rom_data;
  logic [10:0] rom_addr;
  logic [13:0] ir;
  logic [10:0] ir_pc;
  logic [3:0]  stack_lvl;
  logic        stack_ovf;
  logic        stack_unf;

  int total_checks  = 0;
  int passed_checks = 0;

  logic [10:0] push_val [1:9];
  logic [10:0] m_pc;
  logic [10:0] m_ir_pc;
  logic [10:0] tgt;

  pic_fetch_unit dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .jump_en   (jump_en),
    .call_en   (call_en),
    .ret_en    (ret_en),
    .jump_addr (jump_addr),
    .flush     (flush),
    .rom_data  (rom_data),
    .rom_addr  (rom_addr),
    .ir        (ir),
    .ir_pc     (ir_pc),
    .stack_lvl (stack_lvl),
    .stack_ovf (stack_ovf),
    .stack_unf (stack_unf)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] rom_word(input logic [10:0] a);
    case (a)
      11'h000: rom_word = 14'h303C;
      11'h001: rom_word = 14'h00A4;
      11'h004: rom_word = 14'h0825;
      default: rom_word = {3'b101, a};
    endcase
  endfunction

  always_comb rom_data = rom_word(rom_addr);

  task automatic applyStimulus(input logic s, input logic j, input logic c, input logic r,
                               input logic [10:0] addr, input logic f);
    stall     = s;
    jump_en   = j;
    call_en   = c;
    ret_en    = r;
    jump_addr = addr;
    flush     = f;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic checkFetch(input string tag, input logic [10:0] e_addr,
                            input logic [13:0] e_ir, input logic [10:0] e_ir_pc);
    checkOutput({tag, ".rom_addr"}, 32'(rom_addr), 32'(e_addr));
    checkOutput({tag, ".ir"},       32'(ir),       32'(e_ir));
    checkOutput({tag, ".ir_pc"},    32'(ir_pc),    32'(e_ir_pc));
  endtask

  task automatic checkReset(input string tag);
    checkFetch(tag, 11'h000, 14'h0000, 11'h000);
    checkOutput({tag, ".lvl"}, 32'(stack_lvl), 32'd0);
    checkOutput({tag, ".ovf"}, 32'(stack_ovf), 32'd0);
    checkOutput({tag, ".unf"}, 32'(stack_unf), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0);
    #2;
    checkReset("reset");
    #5 reset = 1'b0;

    $display("[TB] sequential fetch");
    tick();
    checkFetch("seq1", 11'h001, 14'h303C, 11'h000);
    tick();
    checkFetch("seq2", 11'h002, 14'h00A4, 11'h001);
    for (int k = 0; k < 8; k++) tick();
    checkFetch("seq10", 11'h00A, rom_word(11'h009), 11'h009);

    $display("[TB] goto");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'h004, 1'b0);
    tick();
    checkFetch("jump", 11'h004, 14'h0000, 11'h00A);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0);
    tick();
    checkFetch("jump_tgt", 11'h005, 14'h0825, 11'h004);

    $display("[TB] flush and stall");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b1);
    tick();
    checkFetch("flush", 11'h006, 14'h0000, 11'h005);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 11'h300, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkFetch("stall", 11'h006, 14'h0000, 11'h005);
      checkOutput("stall.lvl", 32'(stack_lvl), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0);
    tick();
    checkFetch("unstall", 11'h007, rom_word(11'h006), 11'h006);

    $display("[TB] call and return");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'h01F, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0);
    tick();
    tick();
    checkFetch("pre_call", 11'h021, rom_word(11'h020), 11'h020);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 11'h100, 1'b0);
    tick();
    checkFetch("call", 11'h100, 14'h0000, 11'h021);
    checkOutput("call.lvl", 32'(stack_lvl), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0);
    tick();
    checkFetch("callee", 11'h101, rom_word(11'h100), 11'h100);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 11'h000, 1'b0);
    tick();
    checkFetch("ret", 11'h021, 14'h0000, 11'h101);
    checkOutput("ret.lvl", 32'(stack_lvl), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0);
    tick();
    checkFetch("after_ret", 11'h022, rom_word(11'h021), 11'h021);

    $display("[TB] stack overflow and underflow");
    m_ir_pc = 11'h021;
    m_pc    = 11'h022;
    for (int k = 1; k <= 9; k++) begin
      tgt         = 11'h200 + 11'(k * 16);
      push_val[k] = m_ir_pc + 11'd1;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, tgt, 1'b0);
      tick();
      m_ir_pc = m_pc;
      m_pc    = tgt;
      checkOutput("calls.rom_addr", 32'(rom_addr), 32'(tgt));
      checkOutput("calls.lvl", 32'(stack_lvl), (k > 8) ? 32'd8 : 32'(k));
      checkOutput("calls.ovf", 32'(stack_ovf), (k == 9) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 11'h000, 1'b0);
    for (int j = 1; j <= 8; j++) begin
      tick();
      checkOutput("rets.rom_addr", 32'(rom_addr), 32'(push_val[10-j]));
      checkOutput("rets.lvl", 32'(stack_lvl), 32'(8 - j));
      checkOutput("rets.unf", 32'(stack_unf), 32'd0);
    end
    tick();
    checkOutput("unf.rom_addr", 32'(rom_addr), 32'(push_val[9]));
    checkOutput("unf.lvl", 32'(stack_lvl), 32'd0);
    checkOutput("unf.unf", 32'(stack_unf), 32'd1);
    checkOutput("unf.ovf", 32'(stack_ovf), 32'd1);

    $display("[TB] PC wrap and async reset");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'h7FE, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0);
    tick();
    checkOutput("wrap.pre", 32'(rom_addr), 32'h7FF);
    tick();
    checkFetch("wrap", 11'h000, rom_word(11'h7FF), 11'h7FF);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 11'h123, 1'b0);
    tick();
    checkOutput("mid_call.lvl", 32'(stack_lvl), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkReset("async_reset");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0);
    #1 reset = 1'b0;
    tick();
    checkFetch("restart", 11'h001, 14'h303C, 11'h000);
    checkOutput("restart.lvl", 32'(stack_lvl), 32'd0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
